// File: rtl/ca_random_pkg.sv
// ca_random_pkg: shared FSM encoding and width-generic CA helpers (seed derivation, rule-90/150 step).
// Helpers work on CA_MAX_W-bit vectors with the live width passed in; callers cast the result back.
package ca_random_pkg;
  localparam int CA_MAX_W = 128;
  typedef enum logic [1:0] {CA_IDLE = 2'd0, CA_WARMUP = 2'd1, CA_RUN = 2'd2} ca_state_e;
  function automatic logic [CA_MAX_W-1:0] ca_wmask(input int w);
    return {CA_MAX_W{1'b1}} >> (CA_MAX_W - w);
  endfunction
  function automatic logic [CA_MAX_W-1:0] ca_rotl(input logic [CA_MAX_W-1:0] s, input int n, input int w);
    logic [CA_MAX_W-1:0] v;
    int k;
    v = s & ca_wmask(w);
    k = n % w;
    return ((v << k) | (v >> (w - k))) & ca_wmask(w);
  endfunction
  function automatic logic [CA_MAX_W-1:0] ca_derive_seed(input logic [CA_MAX_W-1:0] seed, input int c,
                                                         input int w, input logic [CA_MAX_W-1:0] dflt);
    logic [CA_MAX_W-1:0] r;
    r = ca_rotl(seed, c, w) ^ (CA_MAX_W'(c) & ca_wmask(w));
    return (r == '0) ? (dflt & ca_wmask(w)) : r;
  endfunction
  // lo/hi carry the left and right neighbour of every cell; the boundary bits are patched for wrap
  function automatic logic [CA_MAX_W-1:0] ca_step(input logic [CA_MAX_W-1:0] s, input logic [CA_MAX_W-1:0] mask,
                                                  input int w, input bit cyc);
    logic [CA_MAX_W-1:0] v, lo, hi;
    v = s & ca_wmask(w);
    lo = v << 1;
    hi = v >> 1;
    if (cyc) begin
      lo[0] = v[w-1];
      hi[w-1] = v[0];
    end
    return (lo ^ hi ^ (mask & v)) & ca_wmask(w);
  endfunction
endpackage

// File: rtl/ca_random_row.sv
// ca_random_row: one Width-cell hybrid rule-90/150 CA register with load, step and hold.
module ca_random_row
  import ca_random_pkg::*;
#(
  parameter int Width = 32,
  parameter logic [Width-1:0] RuleMask = Width'(32'h0000_0000),
  parameter int Cyclic = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [Width-1:0] seed_d,
  output logic [Width-1:0] state
);
  logic [Width-1:0] r_s;
  logic [Width-1:0] w_next;
  assign w_next = Width'(ca_step(CA_MAX_W'(r_s), CA_MAX_W'(RuleMask), Width, Cyclic != 0));
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_s <= '0;
    else if (load) r_s <= seed_d;
    else if (step) r_s <= w_next;
  assign state = r_s;
endmodule

// File: rtl/cellular_automata_random_multi.sv
// cellular_automata_random_multi: Channels independent CA random generators with warm-up and valid flag.
// Define CA_RANDOM_WHITEN_EN to add a registered s ^ rot(s, Width/2) output stage (+1 cycle latency).
module cellular_automata_random_multi
  import ca_random_pkg::*;
#(
  parameter int Width = 32,
  parameter int Channels = 4,
  parameter logic [Width-1:0] RuleMask = Width'(32'h0000_0000),
  parameter int Cyclic = 0,
  parameter int WarmupSteps = 16,
  parameter logic [Width-1:0] DefaultSeed = Width'(32'h0000_0001)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ce,
  input  logic                      load,
  input  logic [Width-1:0]          seed,
  output logic                      valid,
  output logic [Channels*Width-1:0] random
);
  localparam int CntW = (WarmupSteps > 0) ? $clog2(WarmupSteps + 1) : 1;
  ca_state_e                 r_state;
  logic [CntW-1:0]           r_cnt;
  logic                      r_valid;
  logic [CntW:0]             w_cnt_nx;
  logic                      w_done;
  logic                      w_step;
  logic [Channels*Width-1:0] w_raw;
  assign w_step   = ce && !load && (r_state != CA_IDLE);
  assign w_cnt_nx = {1'b0, r_cnt} + 1'b1;
  assign w_done   = w_cnt_nx >= (CntW+1)'(WarmupSteps);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= CA_IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_state <= (WarmupSteps == 0) ? CA_RUN : CA_WARMUP;
      r_cnt   <= '0;
      r_valid <= (WarmupSteps == 0);
    end else if (w_step && r_state == CA_WARMUP) begin
      r_cnt   <= w_done ? CntW'(WarmupSteps) : w_cnt_nx[CntW-1:0];
      r_state <= w_done ? CA_RUN : CA_WARMUP;
      r_valid <= w_done;
    end
  for (genvar c = 0; c < Channels; c++) begin : g_ch
    logic [Width-1:0] w_seed;
    assign w_seed = Width'(ca_derive_seed(CA_MAX_W'(seed), c, Width, CA_MAX_W'(DefaultSeed)));
    ca_random_row #(.Width(Width), .RuleMask(RuleMask), .Cyclic(Cyclic)) u_row (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (w_step),
      .seed_d (w_seed),
      .state  (w_raw[c*Width +: Width])
    );
  end
`ifdef CA_RANDOM_WHITEN_EN
  logic [Channels*Width-1:0] w_white;
  logic [Channels*Width-1:0] r_white;
  logic                      r_valid_d;
  for (genvar c = 0; c < Channels; c++) begin : g_wh
    assign w_white[c*Width +: Width] = w_raw[c*Width +: Width]
                                     ^ Width'(ca_rotl(CA_MAX_W'(w_raw[c*Width +: Width]), Width/2, Width));
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_white   <= '0;
      r_valid_d <= 1'b0;
    end else begin
      r_white   <= w_white;
      r_valid_d <= r_valid;
    end
  assign random = r_white;
  assign valid  = r_valid_d;
`else
  assign random = w_raw;
  assign valid  = r_valid;
`endif
endmodule

// File: tb/tb_cellular_automata_random_multi.sv
// tb_cellular_automata_random_multi: bench with a per-cycle behavioural model plus hand-computed literal checks.
module tb_cellular_automata_random_multi;
  localparam logic [7:0] MASK = 8'h96;
  localparam logic [7:0] DSEED = 8'hC3;
  localparam int WS = 3;
`ifdef CA_RANDOM_WHITEN_EN
  localparam bit WH = 1'b1;
`else
  localparam bit WH = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0, load = 1'b0;
  logic [7:0] seed = '0;
  logic valid;
  logic [31:0] random;
  logic l4 = 1'b0, c4 = 1'b0;
  logic [3:0] s4 = '0;
  logic v90, v150, vcyc;
  logic [3:0] r90, r150, rcyc;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  cellular_automata_random_multi #(.Width(8), .Channels(4), .RuleMask(MASK), .Cyclic(0),
    .WarmupSteps(WS), .DefaultSeed(DSEED)) dut (
    .clk(clk), .rst(rst), .ce(ce), .load(load), .seed(seed), .valid(valid), .random(random));
  cellular_automata_random_multi #(.Width(4), .Channels(1), .RuleMask(4'b0000), .Cyclic(0),
    .WarmupSteps(0)) u90 (
    .clk(clk), .rst(rst), .ce(c4), .load(l4), .seed(s4), .valid(v90), .random(r90));
  cellular_automata_random_multi #(.Width(4), .Channels(1), .RuleMask(4'b1111), .Cyclic(0),
    .WarmupSteps(0)) u150 (
    .clk(clk), .rst(rst), .ce(c4), .load(l4), .seed(s4), .valid(v150), .random(r150));
  cellular_automata_random_multi #(.Width(4), .Channels(1), .RuleMask(4'b0000), .Cyclic(1),
    .WarmupSteps(0)) ucyc (
    .clk(clk), .rst(rst), .ce(c4), .load(l4), .seed(s4), .valid(vcyc), .random(rcyc));
  function automatic logic [7:0] ow8(input logic [7:0] x);
    return WH ? (x ^ {x[3:0], x[7:4]}) : x;
  endfunction
  function automatic logic [3:0] ow4(input logic [3:0] x);
    return WH ? (x ^ {x[1:0], x[3:2]}) : x;
  endfunction
  // model: seed bits moved to (i+c) mod 8, then XOR c, zero replaced by default
  function automatic logic [7:0] m_derive(input logic [7:0] s, input int c);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[(i + c) % 8] = s[i];
    r = r ^ 8'(c);
    return (r == 8'h00) ? DSEED : r;
  endfunction
  function automatic logic [7:0] m_step(input logic [7:0] s);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      logic l, r;
      l = (i > 0) ? s[(i + 7) % 8] : 1'b0;
      r = (i < 7) ? s[(i + 1) % 8] : 1'b0;
      n[i] = l ^ r ^ (MASK[i] & s[i]);
    end
    return n;
  endfunction
  logic [7:0] m_st [4] = '{default: 8'h00};
  int m_mode = 0, m_cnt = 0;
  logic m_valid = 1'b0, m_wv = 1'b0;
  logic [31:0] m_wr = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < 4; c++) m_st[c] <= 8'h00;
      m_mode <= 0;
      m_cnt <= 0;
      m_valid <= 1'b0;
      m_wr <= '0;
      m_wv <= 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        m_wr[c*8 +: 8] <= m_st[c] ^ {m_st[c][3:0], m_st[c][7:4]};
        m_st[c] <= load ? m_derive(seed, c) : ((ce && m_mode != 0) ? m_step(m_st[c]) : m_st[c]);
      end
      m_wv <= m_valid;
      if (load) begin
        m_cnt <= 0;
        m_mode <= (WS == 0) ? 2 : 1;
        m_valid <= (WS == 0);
      end else if (ce && m_mode == 1) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 >= WS) begin
          m_mode <= 2;
          m_valid <= 1'b1;
        end
      end
    end
  end
  always @(negedge clk) begin
    logic [31:0] er;
    logic ev;
    er = WH ? m_wr : {m_st[3], m_st[2], m_st[1], m_st[0]};
    ev = WH ? m_wv : m_valid;
    total++;
    if (random !== er) begin
      bad++;
      $display("FAIL model_random got=%h exp=%h t=%0t", random, er, $time);
    end
    total++;
    if (valid !== ev) begin
      bad++;
      $display("FAIL model_valid got=%b exp=%b t=%0t", valid, ev, $time);
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic tick(input logic l, input logic c, input logic [7:0] s);
    load = l;
    ce = c;
    seed = s;
    @(negedge clk);
  endtask
  task automatic tick4(input logic l, input logic c, input logic [3:0] s);
    l4 = l;
    c4 = c;
    s4 = s;
    @(negedge clk);
  endtask
  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_random", random, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    rst = 1'b1;
    repeat (5) tick(1'b0, 1'b1, 8'h00);
    chk("idle_ce_random", random, 32'h0);
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    chk("seed0_ch0_default", {24'b0, random[7:0]}, {24'b0, ow8(DSEED)});
    chk("seed0_ch1", {24'b0, random[15:8]}, {24'b0, ow8(8'h01)});
    chk("seed0_ch2", {24'b0, random[23:16]}, {24'b0, ow8(8'h02)});
    chk("seed0_ch3", {24'b0, random[31:24]}, {24'b0, ow8(8'h03)});
    tick(1'b0, 1'b1, 8'h00);
    chk("warm_step1_valid", {31'b0, valid}, 32'h0);
    tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    chk("warm_step2_valid", {31'b0, valid}, 32'h0);
    tick(1'b0, 1'b1, 8'h00);
    chk("warm_step3_valid", {31'b0, valid}, {31'b0, !WH});
    tick(1'b0, 1'b0, 8'h00);
    chk("run_valid", {31'b0, valid}, 32'h1);
    tick(1'b1, 1'b1, 8'h5A);
    tick(1'b0, 1'b0, 8'h00);
    chk("reload_valid_low", {31'b0, valid}, 32'h0);
    chk("load_ce_ch0_exact", {24'b0, random[7:0]}, {24'b0, ow8(8'h5A)});
    tick(1'b0, 1'b1, 8'h00);
    tick(1'b0, 1'b0, 8'h00);
    chk("step_5a_ch0", {24'b0, random[7:0]}, {24'b0, ow8(8'h8B)});
    for (int i = 0; i < 40; i++) tick(i == 20, (i % 3) != 0, 8'(i * 37));
    repeat (4) tick(1'b0, 1'b1, 8'h00);
    ce = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_random", random, 32'h0);
    chk("async_rst_valid", {31'b0, valid}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) tick(1'b0, 1'b1, 8'h00);
    chk("post_rst_no_load", random, 32'h0);
    ce = 1'b0;
    tick4(1'b1, 1'b0, 4'b0001);
    tick4(1'b0, 1'b1, 4'b0001);
    tick4(1'b0, 1'b0, 4'b0000);
    tick4(1'b0, 1'b0, 4'b0000);
    chk("rule90", {28'b0, r90}, {28'b0, ow4(4'b0010)});
    chk("rule150", {28'b0, r150}, {28'b0, ow4(4'b0011)});
    chk("warm0_valid", {31'b0, v90}, 32'h1);
    tick4(1'b1, 1'b0, 4'b1000);
    tick4(1'b0, 1'b1, 4'b0000);
    tick4(1'b0, 1'b0, 4'b0000);
    tick4(1'b0, 1'b0, 4'b0000);
    chk("cyclic", {28'b0, rcyc}, {28'b0, ow4(4'b0101)});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
